// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit feeder slice.
// Holds the feeder state encoding and the FIFO depth sanity check.
package uart_pkg;

   localparam int UART_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP
   } tx_feed_state_t;

   function automatic bit is_pow2_depth(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Circular byte FIFO: storage, pointers, occupancy count and status flags.
// The registered count is the only source of full/empty.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = UART_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       rd_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full,
   output logic                   overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   generate
      if (!is_pow2_depth(DEPTH)) begin : g_bad_depth
         $error("uart_sync_fifo: DEPTH must be a power of two and at least 2");
      end
   endgenerate

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Flags come from the registered count, so a pop only frees a slot next cycle.
   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign wr_ready = !full;
   assign do_push  = wr_valid && !full;
   assign do_pop   = rd_en && !empty;
   assign rd_data  = mem[rd_ptr];

   // NOTE: storage is deliberately not reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   // NOTE: all state updates are non-blocking so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (wr_valid && full) overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and hands them to uart_top one at a time via dintx/newd,
// pacing on rising edges of donetx with an optional idle gap between bytes.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int WIDTH      = UART_WIDTH,
   parameter int GAP_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       s_data,
   input  logic                   s_valid,
   output logic                   s_ready,
   output logic [WIDTH-1:0]       dintx,
   output logic                   newd,
   input  logic                   donetx,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full,
   output logic                   busy,
   output logic                   overflow
);

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES == 0) ? '0 : GW'(GAP_CYCLES - 1);

   tx_feed_state_t   state;
   logic [GW-1:0]    gap_cnt;
   logic             donetx_q;
   logic             done_rise;
   logic             pop;
   logic [WIDTH-1:0] fifo_data;

   // A donetx already high on entry to SEND produces no rise, so it is ignored.
   assign done_rise = donetx && !donetx_q;
   assign pop       = (state == IDLE) && !empty;

   uart_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_data  (s_data),
      .wr_valid (s_valid),
      .wr_ready (s_ready),
      .rd_en    (pop),
      .rd_data  (fifo_data),
      .count    (count),
      .empty    (empty),
      .full     (full),
      .overflow (overflow)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         dintx    <= '0;
         newd     <= 1'b0;
         busy     <= 1'b0;
         gap_cnt  <= '0;
         donetx_q <= 1'b0;
      end else begin
         donetx_q <= donetx;
         case (state)
            IDLE: begin
               if (!empty) begin
                  dintx <= fifo_data;
                  newd  <= 1'b1;
                  busy  <= 1'b1;
                  state <= SEND;
               end
            end
            SEND: begin
               if (done_rise) begin
                  newd <= 1'b0;
                  if (GAP_CYCLES == 0) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     gap_cnt <= GAP_LOAD;
                     state   <= GAP;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == '0) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt - GW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: scoreboard of pushed bytes against
// the bytes presented on newd, plus per-scenario checks of flags and timing.
module tb_uart_tx_feeder;

   localparam int DEPTH = 16;
   localparam int WIDTH = 8;
   localparam int GAP_N = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [WIDTH-1:0] s_data = '0;
   logic             s_valid = 1'b0;
   logic             s_ready;
   logic [WIDTH-1:0] dintx;
   logic             newd;
   logic             donetx;
   logic [4:0]       count;
   logic             empty;
   logic             full;
   logic             busy;
   logic             overflow;

   logic             man_done = 1'b0;
   logic             resp_done = 1'b0;
   bit               auto_done = 1'b0;

   assign donetx = man_done | resp_done;

   int               n_cmp = 0;
   int               n_err = 0;
   logic [WIDTH-1:0] sb[$];

   uart_tx_feeder #(
      .DEPTH      (DEPTH),
      .WIDTH      (WIDTH),
      .GAP_CYCLES (GAP_N)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .dintx    (dintx),
      .newd     (newd),
      .donetx   (donetx),
      .count    (count),
      .empty    (empty),
      .full     (full),
      .busy     (busy),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   // Scoreboard monitor: every newd assertion must present the oldest pushed byte.
   logic             newd_prev = 1'b0;
   logic [WIDTH-1:0] held = '0;
   logic [WIDTH-1:0] mon_exp;
   int               low_cnt = 0;
   bit               have_prev = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         newd_prev = 1'b0;
         have_prev = 1'b0;
         low_cnt   = 0;
      end else begin
         if (newd && !newd_prev) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL sb_unexpected: newd with dintx=%h, no byte expected", dintx);
            end else begin
               mon_exp = sb.pop_front();
               if (dintx !== mon_exp) begin
                  n_err++;
                  $display("FAIL sb_order: dintx=%h, expected %h", dintx, mon_exp);
               end
            end
            if (have_prev) begin
               n_cmp++;
               if (low_cnt < GAP_N) begin
                  n_err++;
                  $display("FAIL gap_len: newd low %0d cycles, expected >= %0d", low_cnt, GAP_N);
               end
            end
            have_prev = 1'b1;
            held      = dintx;
         end else if (newd) begin
            n_cmp++;
            if (dintx !== held) begin
               n_err++;
               $display("FAIL dintx_stable: dintx=%h changed while newd high, expected %h", dintx, held);
            end
         end
         if (newd) low_cnt = 0;
         else      low_cnt++;
         newd_prev = newd;
      end
   end

   // Modelled uart_top completion: random latency, pulse or multi-cycle level.
   int lat;
   initial begin
      forever begin
         @(negedge clk);
         if (auto_done && newd && !rst && !resp_done) begin
            lat = $urandom_range(0, 3);
            repeat (lat) @(negedge clk);
            resp_done = 1'b1;
            if ($urandom_range(0, 1) == 0) begin
               @(negedge clk);
            end else begin
               repeat (4) @(negedge clk);
            end
            resp_done = 1'b0;
         end
      end
   end

   task automatic push_byte(input logic [WIDTH-1:0] d);
      int waited = 0;
      @(negedge clk);
      while (!s_ready && waited < 500) begin
         s_valid = 1'b0;
         waited++;
         @(negedge clk);
      end
      if (!s_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL push_timeout: s_ready=%b after %0d cycles, expected 1", s_ready, waited);
      end else begin
         s_valid = 1'b1;
         s_data  = d;
         sb.push_back(d);
      end
   endtask

   task automatic wait_drain(input int budget);
      int i = 0;
      while (i < budget && !(sb.size() == 0 && !busy && !newd && !donetx)) begin
         @(negedge clk);
         i++;
      end
      n_cmp++;
      if (i >= budget) begin
         n_err++;
         $display("FAIL drain_timeout: %0d bytes pending, busy=%b after %0d cycles, expected 0/0", sb.size(), busy, budget);
      end
   endtask

   task automatic apply_reset(input int cycles);
      @(negedge clk);
      rst       = 1'b1;
      s_valid   = 1'b0;
      man_done  = 1'b0;
      auto_done = 1'b0;
      repeat (cycles) @(negedge clk);
      sb.delete();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (5) @(negedge clk);
      n_cmp++; if (newd !== 1'b0)     begin n_err++; $display("FAIL rst_newd: %b expected 0", newd); end
      n_cmp++; if (dintx !== 8'h00)   begin n_err++; $display("FAIL rst_dintx: %h expected 00", dintx); end
      n_cmp++; if (count !== 5'd0)    begin n_err++; $display("FAIL rst_count: %0d expected 0", count); end
      n_cmp++; if (empty !== 1'b1)    begin n_err++; $display("FAIL rst_empty: %b expected 1", empty); end
      n_cmp++; if (full !== 1'b0)     begin n_err++; $display("FAIL rst_full: %b expected 0", full); end
      n_cmp++; if (s_ready !== 1'b1)  begin n_err++; $display("FAIL rst_s_ready: %b expected 1", s_ready); end
      n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL rst_busy: %b expected 0", busy); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: %b expected 0", overflow); end
      rst = 1'b0;
      repeat (5) @(negedge clk);
      n_cmp++; if (newd !== 1'b0)     begin n_err++; $display("FAIL idle_newd: %b expected 0", newd); end
   endtask

   task automatic test_single();
      auto_done = 1'b0;
      push_byte(8'hA5);
      @(negedge clk);
      s_valid = 1'b0;
      n_cmp++; if (newd !== 1'b0)   begin n_err++; $display("FAIL single_newd_n: %b expected 0", newd); end
      n_cmp++; if (count !== 5'd1)  begin n_err++; $display("FAIL single_count_n: %0d expected 1", count); end
      @(negedge clk);
      n_cmp++; if (newd !== 1'b1)   begin n_err++; $display("FAIL single_newd_n1: %b expected 1", newd); end
      n_cmp++; if (dintx !== 8'hA5) begin n_err++; $display("FAIL single_dintx: %h expected a5", dintx); end
      n_cmp++; if (count !== 5'd0)  begin n_err++; $display("FAIL single_count_n1: %0d expected 0", count); end
      n_cmp++; if (busy !== 1'b1)   begin n_err++; $display("FAIL single_busy: %b expected 1", busy); end
      repeat (3) @(negedge clk);
      n_cmp++; if (newd !== 1'b1)   begin n_err++; $display("FAIL single_hold: %b expected 1", newd); end
      man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;
      n_cmp++; if (newd !== 1'b0)   begin n_err++; $display("FAIL single_done_newd: %b expected 0", newd); end
      n_cmp++; if (busy !== 1'b1)   begin n_err++; $display("FAIL single_gap_busy: %b expected 1", busy); end
      repeat (4) @(negedge clk);
      n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL single_busy_end: %b expected 0", busy); end
   endtask

   task automatic test_burst();
      auto_done = 1'b1;
      for (int i = 1; i <= 5; i++) push_byte(WIDTH'(i));
      @(negedge clk);
      s_valid = 1'b0;
      wait_drain(2000);
      auto_done = 1'b0;
      n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL burst_count: %0d expected 0", count); end
      n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL burst_busy: %b expected 0", busy); end
   endtask

   task automatic test_full();
      int i;
      auto_done = 1'b0;
      for (int k = 0; k < DEPTH + 1; k++) push_byte(8'h40 + WIDTH'(k));
      @(negedge clk);
      s_valid = 1'b0;
      n_cmp++; if (count !== 5'd16)   begin n_err++; $display("FAIL full_count: %0d expected 16", count); end
      n_cmp++; if (full !== 1'b1)     begin n_err++; $display("FAIL full_flag: %b expected 1", full); end
      n_cmp++; if (s_ready !== 1'b0)  begin n_err++; $display("FAIL full_s_ready: %b expected 0", s_ready); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_ovf_pre: %b expected 0", overflow); end
      n_cmp++; if (dintx !== 8'h40)   begin n_err++; $display("FAIL full_inflight: %h expected 40", dintx); end
      s_valid = 1'b1;
      s_data  = 8'hEE;
      @(negedge clk);
      s_valid = 1'b0;
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL full_ovf_set: %b expected 1", overflow); end
      n_cmp++; if (count !== 5'd16)   begin n_err++; $display("FAIL full_drop: count %0d expected 16", count); end
      man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;
      i = 0;
      while (!newd && i < 20) begin
         @(negedge clk);
         i++;
      end
      n_cmp++; if (newd !== 1'b1)     begin n_err++; $display("FAIL full_next_newd: %b expected 1", newd); end
      n_cmp++; if (count !== 5'd15)   begin n_err++; $display("FAIL full_pop_count: %0d expected 15", count); end
      n_cmp++; if (s_ready !== 1'b1)  begin n_err++; $display("FAIL full_ready_back: %b expected 1", s_ready); end
      auto_done = 1'b1;
      wait_drain(3000);
      auto_done = 1'b0;
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: %b expected 1", overflow); end
   endtask

   task automatic test_wrap();
      int g;
      auto_done = 1'b1;
      for (int k = 0; k < 40; k++) begin
         g = $urandom_range(0, 2);
         if (g > 0) begin
            @(negedge clk);
            s_valid = 1'b0;
            repeat (g - 1) @(negedge clk);
         end
         push_byte(WIDTH'($urandom_range(0, 255)));
      end
      @(negedge clk);
      s_valid = 1'b0;
      wait_drain(5000);
      auto_done = 1'b0;
      n_cmp++; if (count !== 5'd0)    begin n_err++; $display("FAIL wrap_count: %0d expected 0", count); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL wrap_overflow: %b expected 0", overflow); end
   endtask

   task automatic test_reset_mid();
      auto_done = 1'b0;
      for (int k = 0; k < 4; k++) push_byte(8'hC0 + WIDTH'(k));
      @(negedge clk);
      s_valid = 1'b0;
      n_cmp++; if (newd !== 1'b1)   begin n_err++; $display("FAIL mid_pre_newd: %b expected 1", newd); end
      n_cmp++; if (count !== 5'd3)  begin n_err++; $display("FAIL mid_pre_count: %0d expected 3", count); end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (newd !== 1'b0)   begin n_err++; $display("FAIL mid_newd: %b expected 0", newd); end
      n_cmp++; if (count !== 5'd0)  begin n_err++; $display("FAIL mid_count: %0d expected 0", count); end
      n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL mid_busy: %b expected 0", busy); end
      n_cmp++; if (empty !== 1'b1)  begin n_err++; $display("FAIL mid_empty: %b expected 1", empty); end
      sb.delete();
      rst = 1'b0;
      repeat (10) @(negedge clk);
      n_cmp++; if (newd !== 1'b0)   begin n_err++; $display("FAIL mid_after_newd: %b expected 0", newd); end
      n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL mid_after_busy: %b expected 0", busy); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_full();
      apply_reset(2);
      test_wrap();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
